// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [2:0] {
        SCAN     = 3'd0,
        DEBOUNCE = 3'd1,
        HELD     = 3'd2,
        RELEASE  = 3'd3
    } state_t;

    localparam logic [3:0] KEY_NONE = 4'hF;

    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } key_entry_t;

    // Indexed {row, col}; the '#' position (r3, c2) is marked invalid.
    localparam key_entry_t KEY_MAP [16] = '{
        5'h11, 5'h12, 5'h13, 5'h1A,
        5'h14, 5'h15, 5'h16, 5'h1B,
        5'h17, 5'h18, 5'h19, 5'h1C,
        5'h1E, 5'h10, 5'h0F, 5'h1D
    };

    function automatic key_entry_t key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Row input synchronizer of configurable depth; every stage resets to all-ones (no key).
module keypad_row_sync #(
    parameter int unsigned DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_rows,
    output logic [3:0] o_rows
);

    logic [3:0] r_pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) r_pipe[i] <= 4'hF;
        end else begin
            r_pipe[0] <= i_rows;
            for (int i = 1; i < int'(DEPTH); i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_rows = r_pipe[DEPTH-1];

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and key encoding.
// Define KEYPAD_SYNC2_EN for a two-flop row synchronizer (default: single flop).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] sample,
    output logic       key_valid,
    output logic [3:0] debug
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV) + 1;
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CNT) + 1;
`ifdef KEYPAD_SYNC2_EN
    localparam int unsigned SYNC_DEPTH = 2;
`else
    localparam int unsigned SYNC_DEPTH = 1;
`endif

    state_t             r_state;
    logic [3:0]         r_col;
    logic [DIV_W-1:0]   r_div;
    logic [DEB_W-1:0]   r_deb;
    logic [3:0]         r_rows_lat;
    logic [3:0]         r_sample;
    logic               r_key_valid;

    logic [3:0]         w_rows_s;
    logic [1:0]         w_col_idx;
    logic [3:0]         w_valid_col;
    logic [3:0]         w_code_col [4];
    logic [3:0]         w_press_mask;
    logic [3:0]         w_lat_mask;
    logic               w_pressed;
    logic [3:0]         w_key_code;
    key_entry_t         w_entry;

    keypad_row_sync #(.DEPTH(SYNC_DEPTH)) u_row_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_rows (row_i),
        .o_rows (w_rows_s)
    );

    // Decode the driven column, mask the '#' position and pick the lowest low row.
    always_comb begin
        w_col_idx   = 2'd0;
        w_valid_col = '0;
        w_entry     = '0;
        w_key_code  = KEY_NONE;
        for (int c = 0; c < 4; c++) begin
            if (!r_col[c]) w_col_idx = 2'(c);
        end
        for (int r = 0; r < 4; r++) begin
            w_entry        = key_lookup(2'(r), w_col_idx);
            w_valid_col[r] = w_entry.valid;
            w_code_col[r]  = w_entry.code;
        end
        w_press_mask = ~w_rows_s & w_valid_col;
        w_lat_mask   = ~r_rows_lat & w_valid_col;
        w_pressed    = |w_press_mask;
        for (int r = 3; r >= 0; r--) begin
            if (w_lat_mask[r]) w_key_code = w_code_col[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= SCAN;
            r_col       <= 4'b1110;
            r_div       <= '0;
            r_deb       <= '0;
            r_rows_lat  <= 4'hF;
            r_sample    <= KEY_NONE;
            r_key_valid <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (r_div == DIV_W'(SCAN_DIV - 1)) begin
                        // Divider is left at terminal so a failed debounce re-samples at once.
                        if (w_pressed) begin
                            r_rows_lat <= w_rows_s;
                            r_deb      <= '0;
                            r_state    <= DEBOUNCE;
                        end else begin
                            r_div <= '0;
                            r_col <= {r_col[2:0], r_col[3]};
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (w_rows_s != r_rows_lat) begin
                        r_state <= SCAN;
                    end else if (r_deb == DEB_W'(DEBOUNCE_CNT - 1)) begin
                        r_state     <= HELD;
                        r_sample    <= w_key_code;
                        r_key_valid <= 1'b1;
                    end else begin
                        r_deb <= r_deb + DEB_W'(1);
                    end
                end
                HELD: begin
                    if (w_rows_s == 4'hF) begin
                        r_deb   <= '0;
                        r_state <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (w_rows_s != 4'hF) begin
                        r_state <= HELD;
                    end else if (r_deb == DEB_W'(DEBOUNCE_CNT - 1)) begin
                        r_sample <= KEY_NONE;
                        r_div    <= '0;
                        r_state  <= SCAN;
                    end else begin
                        r_deb <= r_deb + DEB_W'(1);
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign col_o     = r_col;
    assign sample    = r_sample;
    assign key_valid = r_key_valid;
    assign debug     = {1'b0, r_state};

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a switch-matrix keypad model.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 8;
`ifdef KEYPAD_SYNC2_EN
    localparam int SYNC_LAG = 2;
`else
    localparam int SYNC_LAG = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_i;
    logic [3:0]  col_o;
    logic [3:0]  sample;
    logic        key_valid;
    logic [3:0]  debug;
    logic [15:0] keys;

    int          n_vec  = 0;
    int          n_err  = 0;
    int          n_kv   = 0;
    int          n_viol = 0;
    logic [3:0]  mon_exp     = 4'hF;
    logic [3:0]  prev_sample = 4'hF;
    logic [3:0]  slog [$];

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_i     (row_i),
        .col_o     (col_o),
        .sample    (sample),
        .key_valid (key_valid),
        .debug     (debug)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Switch matrix: a closed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) row_i[r] = ~|(keys[r*4 +: 4] & ~col_o);
    end

    // Protocol watch: pulse only on F->key, no key->key step, no unexpected code.
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid) n_kv <= n_kv + 1;
            if ((key_valid != (prev_sample == 4'hF && sample != 4'hF)) ||
                (prev_sample != 4'hF && sample != 4'hF && sample != prev_sample) ||
                (sample != 4'hF && sample != mon_exp))
                n_viol <= n_viol + 1;
        end
        if (sample != prev_sample) slog.push_back(sample);
        prev_sample <= sample;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_kv(input string tag, input int budget);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!key_valid && i < budget);
        check(tag, 32'(key_valid), 32'd1);
    endtask

    task automatic wait_sample(input string tag, input logic [3:0] exp, input int budget);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (sample != exp && i < budget);
        check(tag, 32'(sample), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         kv_base;
        int         changes;
        logic [3:0] last_col;
        logic [3:0] l0, l1, l2;

        rst_n = 1'b0;
        keys  = '0;

        // 1. reset values and idle column rotation
        repeat (3) @(negedge clk);
        check("rst_col", 32'(col_o), 32'hE);
        check("rst_sample", 32'(sample), 32'hF);
        check("rst_kv", 32'(key_valid), 32'd0);
        check("rst_state", 32'(debug), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("scan_col0_hold", 32'(col_o), 32'hE);
        @(negedge clk);
        check("scan_col1", 32'(col_o), 32'hD);
        repeat (4) @(negedge clk);
        check("scan_col2", 32'(col_o), 32'hB);
        repeat (4) @(negedge clk);
        check("scan_col3", 32'(col_o), 32'h7);
        repeat (4) @(negedge clk);
        check("scan_wrap", 32'(col_o), 32'hE);

        // 2. press '5', hold, release with exact release latency
        mon_exp = 4'h5;
        kv_base = n_kv;
        keys    = 16'h0020;
        wait_kv("press5_kv", 100);
        check("press5_code", 32'(sample), 32'h5);
        repeat (100) @(negedge clk);
        check("press5_held", 32'(sample), 32'h5);
        keys = '0;
        repeat (SYNC_LAG + DEB) @(negedge clk);
        check("release5_still", 32'(sample), 32'h5);
        @(negedge clk);
        check("release5_idle", 32'(sample), 32'hF);
        check("press5_pulses", 32'(n_kv - kv_base), 32'd1);

        // 3. bouncing '9'
        mon_exp = 4'h9;
        kv_base = n_kv;
        for (int i = 0; i < 7; i++) begin
            keys[10] = ~keys[10];
            repeat (3) @(negedge clk);
        end
        wait_kv("bounce9_kv", 200);
        check("bounce9_code", 32'(sample), 32'h9);
        keys = '0;
        wait_sample("bounce9_release", 4'hF, 100);
        check("bounce9_pulses", 32'(n_kv - kv_base), 32'd1);

        // 4. '1' and '7' together, then '#' alone
        mon_exp = 4'h1;
        keys    = 16'h0101;
        wait_kv("multi_kv", 100);
        check("multi_code", 32'(sample), 32'h1);
        keys = '0;
        wait_sample("multi_release", 4'hF, 100);
        kv_base  = n_kv;
        keys     = 16'h4000;
        changes  = 0;
        last_col = col_o;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (col_o != last_col) changes++;
            last_col = col_o;
        end
        check("hash_scan_steps", 32'(changes), 32'd25);
        check("hash_no_kv", 32'(n_kv - kv_base), 32'd0);
        check("hash_sample", 32'(sample), 32'hF);
        check("hash_state", 32'(debug), 32'd0);
        keys = '0;

        // 5. 5,F,5 sequence then a short release glitch
        mon_exp = 4'h5;
        repeat (2) @(negedge clk);
        slog.delete();
        kv_base = n_kv;
        keys    = 16'h0020;
        wait_kv("seq_first_kv", 100);
        keys = '0;
        wait_sample("seq_gap", 4'hF, 100);
        keys = 16'h0020;
        wait_kv("seq_second_kv", 100);
        @(negedge clk);
        l0 = 4'h0; l1 = 4'h0; l2 = 4'h0;
        if (slog.size() > 0) l0 = slog[0];
        if (slog.size() > 1) l1 = slog[1];
        if (slog.size() > 2) l2 = slog[2];
        check("seq_len", 32'(slog.size()), 32'd3);
        check("seq_0", 32'(l0), 32'h5);
        check("seq_1", 32'(l1), 32'hF);
        check("seq_2", 32'(l2), 32'h5);
        keys = '0;
        repeat (3) @(negedge clk);
        keys = 16'h0020;
        repeat (30) @(negedge clk);
        check("glitch_sample", 32'(sample), 32'h5);
        check("glitch_log", 32'(slog.size()), 32'd3);
        check("seq_pulses", 32'(n_kv - kv_base), 32'd2);
        keys = '0;
        wait_sample("seq_release", 4'hF, 100);

        // 6. asynchronous reset while holding 'D'
        mon_exp = 4'hD;
        keys    = 16'h8000;
        wait_kv("pressD_kv", 100);
        check("pressD_code", 32'(sample), 32'hD);
        check("pressD_state", 32'(debug), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_sample", 32'(sample), 32'hF);
        check("async_col", 32'(col_o), 32'hE);
        check("async_kv", 32'(key_valid), 32'd0);
        check("async_state", 32'(debug), 32'd0);
        keys = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("resume_col1", 32'(col_o), 32'hD);
        repeat (4) @(negedge clk);
        check("resume_col2", 32'(col_o), 32'hB);

        @(negedge clk);
        check("protocol_violations", 32'(n_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the 4x4 matrix keypad and produces the 4-bit `sample` code that the sum/accumulate logic consumes.
- Scans columns, debounces, and encodes the pressed key.
- Holds the code while the key is pressed; returns to 4'hF (idle) after a debounced release.
- Downstream logic detects keys by a change in `sample` away from 4'hF. A key must therefore always be separated from the next by at least one cycle of 4'hF.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven before the rows are sampled and the scan advances.
DEBOUNCE_CNT, 20000, consecutive cycles a row pattern must stay unchanged to accept a press or a release.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous, active-low reset.
row_i  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
col_o  output  4  keypad column drive, active-low one-hot.
sample  output  4  key code; 4'hF = no key.
key_valid  output  1  one-cycle pulse when `sample` changes from 4'hF to a key code.
debug  output  4  {1'b0, state[2:0]} for the board LEDs.

Behaviour:
- Reset values: col_o=4'b1110, sample=4'hF, key_valid=0, state=SCAN, all counters 0, synchronizer flops all 1.
- Key map, by (row, col) with column 0 = col_o[0]:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E(*) 0 (#) D
  - '#' (r3, c2) is never reported; a press on it is treated as no press.
- row_i passes through a synchronizer. All decisions use the synchronized value `rows_s`.
- SCAN state:
  - div counter counts 0..SCAN_DIV-1 with the current column driven.
  - On the terminal count, if any rows_s bit is low (excluding '#'): latch column and row pattern, go to DEBOUNCE, column stays frozen.
  - Otherwise rotate col_o left by one (1110→1101→1011→0111→1110).
- DEBOUNCE state:
  - Counter increments while rows_s equals the latched pattern.
  - Any mismatch returns to SCAN. Column and counter are not changed, so the same column is re-sampled.
  - After DEBOUNCE_CNT consecutive matching cycles: go to HELD. On the same edge, `sample` takes the code and `key_valid` pulses.
  - If several rows are low in the column, the lowest row index wins.
- HELD state:
  - Column frozen; `sample` holds the code.
  - rows_s==4'hF enters RELEASE with the counter cleared.
  - Presses in other columns are invisible; no rollover handling.
- RELEASE state:
  - Counter increments while rows_s==4'hF; any low row returns to HELD with no new pulse.
  - After DEBOUNCE_CNT cycles: sample=4'hF, state=SCAN, div counter=0, column kept.
- key_valid is high only on the single cycle `sample` leaves 4'hF; it is never asserted in two consecutive cycles.
- `sample` never changes directly from one key code to another; a 4'hF gap of at least one cycle is guaranteed.
- Reset asserted mid-operation forces all reset values immediately (asynchronous).
- Counter widths: $clog2 of the parameter plus 1. Parameters must be ≥2.

Optional Feature:
- KEYPAD_SYNC2_EN defined: two-flop row synchronizer; rows_s lags row_i by 2 cycles.
- Undefined: single-flop synchronizer; 1-cycle lag. FSM timing is otherwise identical.

Decomposition:
- Package keypad_pkg contains:
  - state enum {SCAN, DEBOUNCE, HELD, RELEASE} (3-bit);
  - localparam KEY_NONE=4'hF;
  - a constant 16-entry key-map array indexed {row, col}, with the '#' entry marked invalid.
- One sub-module, keypad_row_sync: parameterized-depth synchronizer, reset to all-ones.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8, KEYPAD_SYNC2_EN defined):
1. Reset: hold rst_n=0 → col_o=1110, sample=F, key_valid=0. Release reset, no keys → col_o cycles 1110,1101,1011,0111 every 4 clocks.
2. Press '5' (row1 low while col_o[1]=0), hold 100 cycles, release → sample=5 with a single key_valid pulse; sample=F 8 stable cycles after rows_s goes high (+2 sync).
3. Bounce on '9': toggle row2 every 3 cycles for 20 cycles, then hold stable → exactly one key_valid, sample=9, never an intermediate code.
4. Press '1' and '7' together (rows 0 and 2, col 0) → sample=1. Press '#' alone → sample stays F, no pulse, scanning continues.
5. Press '5', release, press '5' again → sample sequence 5,F,5 and two key_valid pulses. Short release glitch (3 cycles high) → no F, no second pulse.
6. rst_n pulsed low while in HELD with sample=D → sample=F and col_o=1110 asynchronously; scanning resumes.
